// File: rtl/audio_pkg.sv
// Shared record-path constants and the capture FSM state type.
package audio_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 18;
  localparam logic [ADDR_W-1:0] ADDR_MAX = 18'h3FFFF;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    SHIFT,
    WRITE,
    DONE
  } cap_state_t;

endpackage

// File: rtl/adc_capture_if.sv
// SRAM write bus plus capture status, driven by adc_capture (master) and
// consumed by the top-level SRAM mux / progress display (slave).
interface adc_capture_if;
  import audio_pkg::*;

  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_wdata;
  logic              sram_we;
  logic              bus_own;
  logic              full;
  logic [ADDR_W-1:0] rec_addr;

  modport master (
    output sram_addr, sram_wdata, sram_we, bus_own, full, rec_addr
  );

  modport slave (
    input sram_addr, sram_wdata, sram_we, bus_own, full, rec_addr
  );

endinterface

// File: rtl/i2s_rx_shift.sv
// I2S serial-to-parallel shifter: MSB-first shift register with a bit
// counter. Shifts while en is high until WIDTH bits are held, then raises
// done for exactly one cycle (registered, one edge after the LSB edge).
// clr rewinds the counter so a new sample can start.
module i2s_rx_shift
  import audio_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             din,
  output logic [WIDTH-1:0] data,
  output logic             done
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] NBITS = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

  logic [CNT_W-1:0] bitcnt;

  // Shift register, bit counter and single-cycle done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      data   <= '0;
      bitcnt <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (clr) begin
        bitcnt <= '0;
      end else if (en && (bitcnt < NBITS)) begin
        data   <= {data[WIDTH-2:0], din};
        bitcnt <= bitcnt + CNT_W'(1);
        done   <= (bitcnt == LAST);
      end
    end
  end

endmodule

// File: rtl/adc_capture.sv
// adc_capture: record-path stage. Deserializes the left slot of the WM8731
// ADC I2S stream and writes each sample to SRAM at an incrementing address
// until the buffer is full. Runs entirely on bclk.
// Optional build macro REC_DECIM_EN adds decim[3:0]: only every decim-th
// captured sample is written (0 or 1 = every sample).
module adc_capture #(
  parameter int unsigned              DATA_W   = audio_pkg::DATA_W,
  parameter int unsigned              ADDR_W   = audio_pkg::ADDR_W,
  parameter logic [ADDR_W-1:0]        ADDR_MAX = audio_pkg::ADDR_MAX
) (
  input  logic              bclk,
  input  logic              rst,
  input  logic              record,
  input  logic              addr_clr,
  input  logic              adclrc,
  input  logic              adcdat,
`ifdef REC_DECIM_EN
  input  logic [3:0]        decim,
`endif
  adc_capture_if.master     bus
);
  import audio_pkg::*;

  cap_state_t state;
  cap_state_t state_nx;

  logic              lrc_d;
  logic              lrc_fall;
  logic              lrc_rise;
  logic [ADDR_W-1:0] rec_addr;
  logic              full;
  logic [DATA_W-1:0] shreg;
  logic              shift_done;
  logic              shift_clr;
  logic              shift_en;
  logic              keep;

  // LR clock delayed one cycle for slot-edge detection.
  always_ff @(posedge bclk) begin
    if (rst) lrc_d <= 1'b0;
    else     lrc_d <= adclrc;
  end

  // Slot-edge decode: falling = left slot starts, rising = right slot starts.
  always_comb begin
    lrc_fall = !adclrc && lrc_d;
    lrc_rise = adclrc && !lrc_d;
  end

  // Shifter runs only in SHIFT; any other state rewinds its counter.
  always_comb begin
    shift_en  = (state == SHIFT);
    shift_clr = (state != SHIFT);
  end

  i2s_rx_shift #(.WIDTH(DATA_W)) u_shift (
    .clk  (bclk),
    .rst  (rst),
    .clr  (shift_clr),
    .en   (shift_en),
    .din  (adcdat),
    .data (shreg),
    .done (shift_done)
  );

`ifdef REC_DECIM_EN
  logic [3:0] dcnt;
  logic [3:0] dlim;
  logic       sample_ok;

  // A sample counts as captured when it completes SHIFT without abort.
  always_comb begin
    sample_ok = (state == SHIFT) && record && !lrc_rise && shift_done;
    keep      = (dcnt == '0);
  end

  // Decimation phase: decim is latched on each kept sample so a change
  // only takes effect from the next kept sample onward.
  always_ff @(posedge bclk) begin
    if (rst || addr_clr) begin
      dcnt <= '0;
      dlim <= '0;
    end else if (sample_ok) begin
      if (dcnt == '0) begin
        dlim <= decim;
        dcnt <= (decim > 4'd1) ? 4'd1 : 4'd0;
      end else begin
        dcnt <= ((dcnt + 4'd1) >= dlim) ? 4'd0 : dcnt + 4'd1;
      end
    end
  end
`else
  // Every captured sample is written.
  always_comb keep = 1'b1;
`endif

  // Capture FSM next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (record && !full) state_nx = SYNC;
      SYNC: begin
        if (!record)       state_nx = IDLE;
        else if (lrc_fall) state_nx = SHIFT;
      end
      SHIFT: begin
        if (!record)         state_nx = IDLE;
        else if (lrc_rise)   state_nx = SYNC;
        else if (shift_done) state_nx = keep ? WRITE : SYNC;
      end
      WRITE: begin
        if (rec_addr == ADDR_MAX) state_nx = DONE;
        else if (record)          state_nx = SYNC;
        else                      state_nx = IDLE;
      end
      DONE:    state_nx = DONE;
      default: state_nx = IDLE;
    endcase
    if (addr_clr) state_nx = IDLE;
  end

  // State, address/full tracking and registered SRAM bus. bus_own stays
  // high for the strobe cycle that follows WRITE even when the FSM moves
  // to DONE/IDLE, so a write never lands without bus ownership.
  always_ff @(posedge bclk) begin
    if (rst) begin
      state          <= IDLE;
      rec_addr       <= '0;
      full           <= 1'b0;
      bus.sram_addr  <= '0;
      bus.sram_wdata <= '0;
      bus.sram_we    <= 1'b0;
      bus.bus_own    <= 1'b0;
    end else begin
      state       <= state_nx;
      bus.sram_we <= (state == WRITE) && !addr_clr;
      bus.bus_own <= (state_nx inside {SYNC, SHIFT, WRITE}) ||
                     ((state == WRITE) && !addr_clr);
      if ((state == WRITE) && !addr_clr) begin
        bus.sram_addr  <= rec_addr;
        bus.sram_wdata <= shreg;
      end
      if (addr_clr) begin
        rec_addr <= '0;
        full     <= 1'b0;
      end else if (state == WRITE) begin
        if (rec_addr == ADDR_MAX) full <= 1'b1;
        else                      rec_addr <= rec_addr + 1'b1;
      end
    end
  end

  // Status outputs.
  always_comb begin
    bus.full     = full;
    bus.rec_addr = rec_addr;
  end

endmodule

// File: tb/tb_adc_capture.sv
// Self-checking bench for adc_capture. Frames are generated as I2S left/right
// slots; a frame-level model predicts which left samples land at which
// address. A small ADDR_MAX override keeps the buffer-full case short.
module tb_adc_capture;
  import audio_pkg::*;

  localparam logic [17:0] TB_MAX = 18'h00013;
  localparam int          H      = 20;

  logic bclk = 1'b0;
  logic rst, record, addr_clr, adclrc, adcdat;
`ifdef REC_DECIM_EN
  logic [3:0] decim;
`endif

  adc_capture_if bus ();

  adc_capture #(.ADDR_MAX(TB_MAX)) dut (
    .bclk     (bclk),
    .rst      (rst),
    .record   (record),
    .addr_clr (addr_clr),
    .adclrc   (adclrc),
    .adcdat   (adcdat),
`ifdef REC_DECIM_EN
    .decim    (decim),
`endif
    .bus      (bus)
  );

  always #5 bclk = ~bclk;

  int unsigned cyc = 0;
  always @(posedge bclk) cyc <= cyc + 1;

  // Write log collected from the SRAM bus.
  logic [17:0] log_addr [512];
  logic [15:0] log_data [512];
  int unsigned log_cyc  [512];
  int unsigned log_n    = 0;
  int unsigned own_viol = 0;

  always @(negedge bclk) begin
    if (bus.sram_we === 1'b1) begin
      if (log_n < 512) begin
        log_addr[log_n] = bus.sram_addr;
        log_data[log_n] = bus.sram_wdata;
        log_cyc[log_n]  = cyc;
      end
      log_n++;
      if (bus.bus_own !== 1'b1) own_viol++;
    end
  end

  // Reference model state.
  logic [17:0] exp_addr [512];
  logic [15:0] exp_data [512];
  int unsigned exp_n   = 0;
  logic [17:0] m_addr  = '0;
  logic        m_full  = 1'b0;
  int unsigned m_dcnt  = 0;
  int unsigned m_decim = 1;
  int unsigned f0      = 0;

  int unsigned checks = 0;
  int unsigned errors = 0;

  task automatic rest(input int n);
    repeat (n) begin
      @(negedge bclk);
      adclrc = 1'b1;
      adcdat = 1'($urandom);
    end
  endtask

  task automatic pulse_clr();
    @(negedge bclk);
    addr_clr = 1'b1;
    @(negedge bclk);
    addr_clr = 1'b0;
    m_addr = '0;
    m_full = 1'b0;
    m_dcnt = 0;
  endtask

  // One I2S frame: left slot then right slot, each with a 1-bit delay
  // slot before the MSB. drop_at >= 0 lowers record at that cycle.
  task automatic send_frame(input logic [15:0] l, input logic [15:0] r,
                            input int drop_at);
    logic rec_start;
    rec_start = record;
    for (int i = 0; i < 2 * H; i++) begin
      @(negedge bclk);
      if (i == drop_at) record = 1'b0;
      if (i < H) begin
        adclrc = 1'b0;
        adcdat = (i >= 1 && i <= 16) ? l[16 - i] : 1'($urandom);
      end else begin
        adclrc = 1'b1;
        adcdat = (i - H >= 1 && i - H <= 16) ? r[16 - (i - H)] : 1'($urandom);
      end
      if (i == 0) f0 = cyc;
    end
    if (rec_start && drop_at < 0 && !m_full) begin
      if (m_dcnt == 0) begin
        exp_addr[exp_n] = m_addr;
        exp_data[exp_n] = l;
        exp_n++;
        if (m_addr == TB_MAX) m_full = 1'b1;
        else                  m_addr = m_addr + 1'b1;
      end
      m_dcnt = (m_dcnt + 1) % m_decim;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; record = 1'b0; addr_clr = 1'b0; adclrc = 1'b1; adcdat = 1'b0;
`ifdef REC_DECIM_EN
    decim = 4'd0;
`endif
    repeat (3) @(negedge bclk);
    checks++; if (bus.sram_addr !== 18'h0) begin errors++; $display("FAIL reset_sram_addr got %h want 0", bus.sram_addr); end
    checks++; if (bus.sram_wdata !== 16'h0) begin errors++; $display("FAIL reset_sram_wdata got %h want 0", bus.sram_wdata); end
    checks++; if (bus.sram_we !== 1'b0) begin errors++; $display("FAIL reset_sram_we got %b want 0", bus.sram_we); end
    checks++; if (bus.bus_own !== 1'b0) begin errors++; $display("FAIL reset_bus_own got %b want 0", bus.bus_own); end
    checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL reset_full got %b want 0", bus.full); end
    checks++; if (bus.rec_addr !== 18'h0) begin errors++; $display("FAIL reset_rec_addr got %h want 0", bus.rec_addr); end
    rst = 1'b0;
    rest(2);
  endtask

  task automatic test_single();
    int unsigned s;
    s = log_n;
    record = 1'b1;
    rest(3);
    send_frame(16'hA5C3, 16'($urandom), -1);
    checks++; if (log_n !== s + 1) begin errors++; $display("FAIL single_count got %0d want %0d", log_n - s, 1); end
    if (log_n == s + 1) begin
      checks++; if (log_addr[s] !== 18'h0) begin errors++; $display("FAIL single_addr got %h want 0", log_addr[s]); end
      checks++; if (log_data[s] !== 16'hA5C3) begin errors++; $display("FAIL single_data got %h want a5c3", log_data[s]); end
      checks++; if (log_cyc[s] - f0 !== 19) begin errors++; $display("FAIL single_latency got %0d want 19", log_cyc[s] - f0); end
    end
    checks++; if (bus.rec_addr !== 18'h1) begin errors++; $display("FAIL single_rec_addr got %h want 1", bus.rec_addr); end
  endtask

  task automatic test_left_only();
    int unsigned s;
    int unsigned hits;
    logic [15:0] lv [3];
    lv[0] = 16'h0001; lv[1] = 16'h8000; lv[2] = 16'hFFFF;
    s = log_n;
    hits = 0;
    for (int f = 0; f < 3; f++) send_frame(lv[f], 16'h1234, -1);
    checks++; if (log_n !== exp_n) begin errors++; $display("FAIL left_count got %0d want %0d", log_n, exp_n); end
    for (int k = s; k < exp_n && k < log_n; k++) begin
      checks++; if (log_addr[k] !== exp_addr[k]) begin errors++; $display("FAIL left_addr got %h want %h", log_addr[k], exp_addr[k]); end
      checks++; if (log_data[k] !== exp_data[k]) begin errors++; $display("FAIL left_data got %h want %h", log_data[k], exp_data[k]); end
      if (log_data[k] === 16'h1234) hits++;
    end
    checks++; if (hits !== 0) begin errors++; $display("FAIL right_slot_written got %0d want 0", hits); end
  endtask

  task automatic test_pause();
    int unsigned s;
    logic [17:0] a0;
    s = log_n;
    a0 = bus.rec_addr;
    send_frame(16'($urandom), 16'($urandom), 9);
    checks++; if (log_n !== s) begin errors++; $display("FAIL pause_no_write got %0d want 0", log_n - s); end
    checks++; if (bus.rec_addr !== m_addr) begin errors++; $display("FAIL pause_rec_addr got %h want %h", bus.rec_addr, m_addr); end
    record = 1'b1;
    rest(2);
    send_frame(16'($urandom), 16'($urandom), -1);
    checks++; if (log_n !== exp_n) begin errors++; $display("FAIL resume_count got %0d want %0d", log_n, exp_n); end
    if (log_n == exp_n && log_n > s) begin
      checks++; if (log_addr[s] !== a0) begin errors++; $display("FAIL resume_addr got %h want %h", log_addr[s], a0); end
      checks++; if (log_data[s] !== exp_data[s]) begin errors++; $display("FAIL resume_data got %h want %h", log_data[s], exp_data[s]); end
    end
  endtask

  task automatic test_random();
    int unsigned s;
    int drop;
    s = log_n;
    for (int f = 0; f < 8; f++) begin
      drop = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 16)) : -1;
      send_frame(16'($urandom), 16'($urandom), drop);
      record = 1'b1;
      rest(2);
    end
    checks++; if (log_n !== exp_n) begin errors++; $display("FAIL rand_count got %0d want %0d", log_n, exp_n); end
    for (int k = s; k < exp_n && k < log_n; k++) begin
      checks++; if (log_addr[k] !== exp_addr[k]) begin errors++; $display("FAIL rand_addr got %h want %h", log_addr[k], exp_addr[k]); end
      checks++; if (log_data[k] !== exp_data[k]) begin errors++; $display("FAIL rand_data got %h want %h", log_data[k], exp_data[k]); end
    end
    checks++; if (bus.rec_addr !== m_addr) begin errors++; $display("FAIL rand_rec_addr got %h want %h", bus.rec_addr, m_addr); end
  endtask

`ifdef REC_DECIM_EN
  task automatic test_decim();
    int unsigned s;
    pulse_clr();
    rest(2);
    decim = 4'd3;
    m_decim = 3;
    s = log_n;
    for (int f = 1; f <= 9; f++) send_frame(16'(f), 16'($urandom), -1);
    checks++; if (log_n - s !== 3) begin errors++; $display("FAIL decim_count got %0d want 3", log_n - s); end
    for (int k = s; k < exp_n && k < log_n; k++) begin
      checks++; if (log_addr[k] !== exp_addr[k]) begin errors++; $display("FAIL decim_addr got %h want %h", log_addr[k], exp_addr[k]); end
      checks++; if (log_data[k] !== exp_data[k]) begin errors++; $display("FAIL decim_data got %h want %h", log_data[k], exp_data[k]); end
    end
    decim = 4'd0;
    m_decim = 1;
  endtask
`endif

  task automatic test_full();
    int unsigned s;
    int guard;
    pulse_clr();
    checks++; if (bus.rec_addr !== 18'h0) begin errors++; $display("FAIL full_clr_addr got %h want 0", bus.rec_addr); end
    rest(2);
    guard = 0;
    while (m_addr != TB_MAX - 1 && guard < 64) begin
      send_frame(16'($urandom), 16'($urandom), -1);
      guard++;
    end
    checks++; if (bus.rec_addr !== TB_MAX - 1) begin errors++; $display("FAIL full_preload got %h want %h", bus.rec_addr, TB_MAX - 1); end
    checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL full_early got %b want 0", bus.full); end
    s = log_n;
    send_frame(16'($urandom), 16'($urandom), -1);
    send_frame(16'($urandom), 16'($urandom), -1);
    checks++; if (log_n - s !== 2) begin errors++; $display("FAIL full_last_count got %0d want 2", log_n - s); end
    if (log_n - s == 2) begin
      checks++; if (log_addr[s] !== TB_MAX - 1) begin errors++; $display("FAIL full_addr_m1 got %h want %h", log_addr[s], TB_MAX - 1); end
      checks++; if (log_addr[s + 1] !== TB_MAX) begin errors++; $display("FAIL full_addr_max got %h want %h", log_addr[s + 1], TB_MAX); end
      checks++; if (log_data[s + 1] !== exp_data[s + 1]) begin errors++; $display("FAIL full_data got %h want %h", log_data[s + 1], exp_data[s + 1]); end
    end
    checks++; if (bus.full !== 1'b1) begin errors++; $display("FAIL full_flag got %b want 1", bus.full); end
    checks++; if (bus.bus_own !== 1'b0) begin errors++; $display("FAIL full_bus_own got %b want 0", bus.bus_own); end
    checks++; if (bus.rec_addr !== TB_MAX) begin errors++; $display("FAIL full_rec_addr got %h want %h", bus.rec_addr, TB_MAX); end
    s = log_n;
    send_frame(16'($urandom), 16'($urandom), -1);
    send_frame(16'($urandom), 16'($urandom), -1);
    checks++; if (log_n !== s) begin errors++; $display("FAIL full_sticky got %0d want 0", log_n - s); end
    checks++; if (bus.full !== 1'b1) begin errors++; $display("FAIL full_sticky_flag got %b want 1", bus.full); end
  endtask

  task automatic test_addr_clr();
    int unsigned s;
    @(negedge bclk);
    addr_clr = 1'b1;
    @(negedge bclk);
    addr_clr = 1'b0;
    m_addr = '0; m_full = 1'b0; m_dcnt = 0;
    checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL clr_full got %b want 0", bus.full); end
    checks++; if (bus.rec_addr !== 18'h0) begin errors++; $display("FAIL clr_rec_addr got %h want 0", bus.rec_addr); end
    checks++; if (bus.bus_own !== 1'b0) begin errors++; $display("FAIL clr_idle got %b want 0", bus.bus_own); end
    @(negedge bclk);
    checks++; if (bus.bus_own !== 1'b1) begin errors++; $display("FAIL clr_resync got %b want 1", bus.bus_own); end
    rest(2);
    s = log_n;
    send_frame(16'($urandom), 16'($urandom), -1);
    checks++; if (log_n - s !== 1) begin errors++; $display("FAIL restart_count got %0d want 1", log_n - s); end
    if (log_n - s == 1) begin
      checks++; if (log_addr[s] !== 18'h0) begin errors++; $display("FAIL restart_addr got %h want 0", log_addr[s]); end
      checks++; if (log_data[s] !== exp_data[exp_n - 1]) begin errors++; $display("FAIL restart_data got %h want %h", log_data[s], exp_data[exp_n - 1]); end
    end
  endtask

  task automatic test_bus_own();
    checks++; if (own_viol !== 0) begin errors++; $display("FAIL we_without_own got %0d want 0", own_viol); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_left_only();
    test_pause();
    test_random();
`ifdef REC_DECIM_EN
    test_decim();
`endif
    test_full();
    test_addr_clr();
    test_bus_own();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errors);
    $finish;
  end

endmodule
